// File: rtl/fir_decim_quant.sv
// Decimate a FIR output stream, quantize kept samples (round-half-up, shift,
// saturate) and buffer the results in a 4-entry output FIFO.
// Sticky flags report saturation (sat_o) and samples lost on a full FIFO (ovf_o).
module fir_decim_quant #(
    parameter int DECIM = 4,
    parameter int SHIFT = 11,
    parameter int OUT_W = 12
) (
    input  logic             clk_i,
    input  logic             rstn_i,
    input  logic             valid_i,
    input  logic [26:0]      data_i,
    input  logic             clr_i,
    output logic             valid_o,
    output logic [OUT_W-1:0] data_o,
    input  logic             ready_i,
    output logic             sat_o,
    output logic             ovf_o
);

    localparam int CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic signed [27:0] RND  = 28'(1) << (SHIFT - 1);
    localparam logic signed [27:0] MAXV = 28'((1 << (OUT_W - 1)) - 1);
    localparam logic signed [27:0] MINV = -MAXV - 28'sd1;

    logic [CNT_W-1:0]       dec_cnt;
    logic                   keep;
    logic signed [27:0]     t_val;
    logic signed [27:0]     q_val;
    logic [OUT_W-1:0]       q_res;
    logic                   q_clamp;

    logic                   s1_valid;
    logic [OUT_W-1:0]       s1_data;

    logic [OUT_W-1:0]       mem [4];
    logic [1:0]             wr_ptr;
    logic [1:0]             rd_ptr;
    logic [2:0]             count;
    logic                   fifo_full;
    logic                   rd_en;
    logic                   wr_en;
    logic                   drop;

    assign keep = valid_i && (dec_cnt == '0);

    // Round, shift and clamp the incoming sample; 28-bit math cannot wrap.
    always_comb begin
        t_val   = $signed({data_i[26], data_i}) + RND;
        q_val   = t_val >>> SHIFT;
        q_res   = q_val[OUT_W-1:0];
        q_clamp = 1'b0;
        if (q_val > MAXV) begin
            q_res   = MAXV[OUT_W-1:0];
            q_clamp = 1'b1;
        end else if (q_val < MINV) begin
            q_res   = MINV[OUT_W-1:0];
            q_clamp = 1'b1;
        end
    end

    assign fifo_full = (count == 3'd4);
    assign valid_o   = (count != 3'd0);
    assign rd_en     = valid_o && ready_i;
    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign wr_en     = s1_valid && (!fifo_full || rd_en);
    assign drop      = s1_valid && fifo_full && !rd_en;
    assign data_o    = valid_o ? mem[rd_ptr] : '0;

    // Decimation counter advances only on valid input samples.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            dec_cnt <= '0;
        end else if (valid_i) begin
            if (dec_cnt == CNT_W'(DECIM - 1)) dec_cnt <= '0;
            else                              dec_cnt <= dec_cnt + 1'b1;
        end
    end

    // Stage 1: register the quantized kept sample.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
        end else begin
            s1_valid <= keep;
            if (keep) s1_data <= q_res;
        end
    end

    // FIFO storage; contents are only meaningful while count covers them.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem[wr_ptr] <= s1_data;
    end

    // Stage 2: FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 2'd1;
            if (rd_en) rd_ptr <= rd_ptr + 2'd1;
            case ({wr_en, rd_en})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    // Sticky flags: a set event in the same cycle as clr_i wins.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sat_o <= 1'b0;
            ovf_o <= 1'b0;
        end else begin
            if (keep && q_clamp) sat_o <= 1'b1;
            else if (clr_i)      sat_o <= 1'b0;
            if (drop)            ovf_o <= 1'b1;
            else if (clr_i)      ovf_o <= 1'b0;
        end
    end

endmodule

// File: doc/fir_decim_quant.md
FIR_DECIM_QUANT -- requirements
Module: fir_decim_quant

Interface
REQ-001 Parameter DECIM, default 4: decimation ratio, legal range 1..16.
REQ-002 Parameter SHIFT, default 11: right-shift applied to the FIR output, legal range 1..20.
REQ-003 Parameter OUT_W, default 12: output sample width.
REQ-004 clk_i  input  1  clock; all state changes on the rising edge.
REQ-005 rstn_i  input  1  reset; asynchronous, active-low.
REQ-006 valid_i  input  1  FIR output sample valid; one sample per high cycle.
REQ-007 data_i  input  27  FIR output sample, signed two's complement.
REQ-008 clr_i  input  1  synchronous clear of the sticky flags only.
REQ-009 valid_o  output  1  output FIFO non-empty.
REQ-010 data_o  output  OUT_W  output sample, signed, equal to the FIFO head.
REQ-011 ready_i  input  1  downstream accepts data_o when valid_o and ready_i are both high.
REQ-012 sat_o  output  1  sticky flag: some kept sample saturated.
REQ-013 ovf_o  output  1  sticky flag: some kept sample was dropped on a full FIFO.

Function
REQ-014 The decimation counter, range 0..DECIM-1, shall advance only on cycles with valid_i=1 and wrap from DECIM-1 to 0.
REQ-015 A valid_i sample shall be kept when the counter equals 0 and discarded otherwise, so the first sample after reset is kept.
REQ-016 Rounding: on a kept sample, compute t = data_i + 2^(SHIFT-1) in 28-bit signed arithmetic with no wrap.
REQ-017 Shift: q = t arithmetically right-shifted by SHIFT (round-half-up).
REQ-018 Saturation: if q > 2^(OUT_W-1)-1, result = 2^(OUT_W-1)-1; if q < -2^(OUT_W-1), result = -2^(OUT_W-1); else result = q.
REQ-019 When REQ-018 clamps a kept sample, the block shall set sat_o.
REQ-020 The rounded, saturated result shall be registered in a quantization stage on the edge that samples the kept valid_i; this is pipeline stage 1.
REQ-021 Stage 1 shall write the output FIFO on the next edge; this is stage 2.
REQ-022 Latency: with the FIFO empty, valid_o shall be high in the cycle after the second edge following the kept valid_i.
REQ-023 Output FIFO: depth 4, first-in first-out, with independent read and write pointers and an occupancy count.
REQ-024 A read shall occur on each edge with valid_o=1 and ready_i=1.
REQ-025 data_o shall show the FIFO head combinationally from registered storage.
REQ-026 When the FIFO is full with no read that cycle, a write shall be dropped, FIFO contents shall be unchanged, and ovf_o shall be set.
REQ-027 When the FIFO is full and a read and a write occur in the same cycle, both shall be performed and ovf_o shall not be set.
REQ-028 When the FIFO is empty, ready_i shall be ignored; no underflow shall occur and pointers shall not move.
REQ-029 Pointers shall wrap modulo 4.
REQ-030 clr_i=1 shall clear sat_o and ovf_o on the next edge.
REQ-031 If clr_i and a new set event occur in the same cycle, the set shall win.
REQ-032 The block shall apply no backpressure upstream: valid_i is never stalled, and loss is reported only through ovf_o.
REQ-033 Decimation shall be independent of ready_i.

Reset
REQ-034 While rstn_i=0, outputs shall be: valid_o=0, data_o=0, sat_o=0, ovf_o=0.
REQ-035 While rstn_i=0, the decimation counter, stage-1 valid, FIFO pointers and FIFO count shall be 0.
REQ-036 Reset assertion mid-operation shall discard all in-flight and buffered samples immediately, without waiting for a clock edge.
REQ-037 After rstn_i deasserts, the next valid_i sample shall be kept.

Verification (DECIM=4, SHIFT=11, OUT_W=12)
REQ-038 Rounding: kept inputs 2048, 1023, 1024, -1024, -1025 -> data_o 1, 0, 1, 0, -1 in order; sat_o stays 0.
REQ-039 Saturation: kept inputs 67108863 and -67108864 -> data_o 2047 and -2048; sat_o=1; clr_i pulse -> sat_o=0 next cycle.
REQ-040 Decimation with gaps: 8 valid samples k*2048 (k=0..7), with valid_i low on alternate cycles, ready_i=1 -> outputs exactly 0 then 4; valid_o high exactly 2 cycles in total.
REQ-041 Backpressure: ready_i=0 while 5 samples are kept (values 1..5 after quantization) -> FIFO holds 1..4 and ovf_o=1; then ready_i=1 -> 1, 2, 3, 4 out on 4 consecutive cycles, then valid_o=0.
REQ-042 Full with simultaneous read and write: FIFO full and ready_i=1 on the same cycle a stage-1 write arrives -> no drop, ovf_o stays 0, order preserved.
REQ-043 Reset mid-stream: rstn_i pulsed low with 3 entries buffered -> valid_o=0 immediately; first valid_i after release is kept and appears 2 edges later.
